// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// State encoding, reset address and small decode helpers.
package if_fetch_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        IF_ISSUE0  = 3'd0,
        IF_ISSUE1  = 3'd1,
        IF_ISSUE2  = 3'd2,
        IF_ISSUE3  = 3'd3,
        IF_CAPTURE = 3'd4,
        IF_DONE    = 3'd5
    } if_state_e;

    function automatic logic is_issue(input if_state_e s);
        logic [2:0] v;
        v = s;
        return (v[2] == 1'b0);
    endfunction

    // Byte lane requested by an ISSUE state.
    function automatic logic [1:0] issue_idx(input if_state_e s);
        logic [2:0] v;
        v = s;
        return v[1:0];
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: reads a 32-bit word as four little-endian bytes
// over a byte-wide port and hands it to decode with a valid/stall handshake.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_sig_i,
    input  logic [31:0] br_target_i,
    input  logic        mem_busy_i,
    input  logic [7:0]  mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    if_state_e       state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic            pend_q, pend_d;
    logic [1:0]      pidx_q, pidx_d;
    logic [3:0][7:0] bytes_q, bytes_d;
    logic            valid_q, valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     pco_q, pco_d;
    logic            issue;
    logic            grant;
    logic            accept;

    assign issue  = is_issue(state_q);
    assign grant  = issue && !mem_busy_i && !br_sig_i;
    assign accept = (state_q == IF_DONE) && !stall_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IF_ISSUE0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (br_sig_i) begin
            state_d = IF_ISSUE0;
        end else begin
            unique case (state_q)
                IF_ISSUE0:  if (!mem_busy_i) state_d = IF_ISSUE1;
                IF_ISSUE1:  if (!mem_busy_i) state_d = IF_ISSUE2;
                IF_ISSUE2:  if (!mem_busy_i) state_d = IF_ISSUE3;
                IF_ISSUE3:  if (!mem_busy_i) state_d = IF_CAPTURE;
                IF_CAPTURE: state_d = IF_DONE;
                IF_DONE:    if (!stall_i) state_d = IF_ISSUE0;
                default:    state_d = IF_ISSUE0;
            endcase
        end
    end

    // Port outputs are combinational and forced low while in reset.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        if (rst && issue) begin
            mem_req_o  = !mem_busy_i && !br_sig_i;
            mem_addr_o = fpc_q + {30'b0, issue_idx(state_q)};
        end
    end

    always_comb begin
        pend_d  = grant;
        pidx_d  = issue_idx(state_q);
        bytes_d = bytes_q;
        fpc_d   = fpc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        pco_d   = pco_q;
        // Read data lands one cycle after the grant, busy or not.
        if (pend_q) begin
            bytes_d[pidx_q] = mem_data_i;
        end
        if (br_sig_i) begin
            fpc_d   = {br_target_i[31:2], 2'b00};
            valid_d = 1'b0;
            pend_d  = 1'b0;
        end else if (state_q == IF_CAPTURE) begin
            valid_d = 1'b1;
            inst_d  = bytes_d;
            pco_d   = fpc_q + 32'd4;
        end else if (accept) begin
            valid_d = 1'b0;
            fpc_d   = fpc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q   <= RESET_PC;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
            inst_q  <= '0;
            pco_q   <= '0;
        end else begin
            fpc_q   <= fpc_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pco_q   <= pco_d;
        end
    end

    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign pc_o         = pco_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory responder, a transaction-level
// fetch model compared every cycle, and directed literal checkpoints.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_sig_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        mem_busy_i = 1'b0;
    logic [7:0]  mem_data_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .br_sig_i    (br_sig_i),
        .br_target_i (br_target_i),
        .mem_busy_i  (mem_busy_i),
        .mem_data_i  (mem_data_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .inst_valid_o(inst_valid_o),
        .inst_o      (inst_o),
        .pc_o        (pc_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Boot word 0x00100513 at 0..3; elsewhere a per-address pattern.
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (a < 32'd4) begin
            case (a[1:0])
                2'd0: return 8'h13;
                2'd1: return 8'h05;
                2'd2: return 8'h10;
                default: return 8'h00;
            endcase
        end
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {mem_rd(a + 32'd3), mem_rd(a + 32'd2),
                mem_rd(a + 32'd1), mem_rd(a)};
    endfunction

    // Model: address of the word being fetched, bytes granted so far,
    // and the cycle of the last grant (word valid two cycles later).
    logic [31:0] m_pc;
    int          grants;
    int          last_grant;
    int          cyc;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        rsp_v;
    logic [31:0] rsp_a;

    task automatic model_reset();
        m_pc       = 32'h0;
        grants     = 0;
        last_grant = -10;
        cyc        = 0;
        rsp_v      = 1'b0;
        rsp_a      = '0;
    endtask

    task automatic step_pre();
        mem_data_i = rsp_v ? mem_rd(rsp_a) : 8'($urandom);
        #1;
        exp_valid = (grants == 4) && (cyc >= last_grant + 2);
        exp_req   = (grants < 4) && !mem_busy_i && !br_sig_i;
        exp_addr  = m_pc + 32'(grants);
        chk("mem_req", 32'(mem_req_o), 32'(exp_req));
        if (exp_req) chk("mem_addr", mem_addr_o, exp_addr);
        chk("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst", inst_o, word(m_pc));
            chk("pc", pc_o, m_pc + 32'd4);
        end
    endtask

    task automatic step_post();
        rsp_v = mem_req_o;
        rsp_a = mem_addr_o;
        if (br_sig_i) begin
            m_pc   = br_target_i & ~32'h3;
            grants = 0;
        end else if (exp_valid && !stall_i) begin
            m_pc   = m_pc + 32'd4;
            grants = 0;
        end else if (exp_req) begin
            grants++;
            if (grants == 4) last_grant = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_req", 32'(mem_req_o), 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        rst = 1'b1;

        // Boot fetch, then stall three cycles in DONE.
        for (int r = 0; r < 9; r++) begin
            stall_i = (r >= 5 && r <= 7);
            step_pre();
            if (r == 5) begin
                chk("boot_valid", 32'(inst_valid_o), 32'h1);
                chk("boot_inst", inst_o, 32'h0010_0513);
                chk("boot_pc", pc_o, 32'h4);
            end
            if (r == 8) chk("stall_inst", inst_o, 32'h0010_0513);
            step_post();
        end
        stall_i = 1'b0;

        // Port busy for two cycles while in ISSUE1.
        for (int r = 0; r < 8; r++) begin
            mem_busy_i = (r == 1 || r == 2);
            step_pre();
            if (r == 0) chk("after_stall_addr", mem_addr_o, 32'h4);
            if (r == 1 || r == 2) chk("busy_req", 32'(mem_req_o), 32'h0);
            if (r == 6) chk("busy_notyet", 32'(inst_valid_o), 32'h0);
            if (r == 7) begin
                chk("busy_valid", 32'(inst_valid_o), 32'h1);
                chk("busy_inst", inst_o, 32'h5D5C_5F5E);
            end
            step_post();
        end
        mem_busy_i = 1'b0;

        // Redirect in ISSUE2, then redirect+stall in DONE to the top word.
        for (int r = 0; r < 18; r++) begin
            br_sig_i    = (r == 2 || r == 8);
            br_target_i = (r == 8) ? 32'hFFFF_FFFC : 32'h0000_0103;
            stall_i     = (r == 8);
            step_pre();
            if (r == 3) chk("redir_addr", mem_addr_o, 32'h100);
            if (r == 8) chk("redir_pc", pc_o, 32'h104);
            if (r == 9) begin
                chk("redir_stall_valid", 32'(inst_valid_o), 32'h0);
                chk("wrap_addr0", mem_addr_o, 32'hFFFF_FFFC);
            end
            if (r == 12) chk("wrap_addr3", mem_addr_o, 32'hFFFF_FFFF);
            if (r == 14) chk("wrap_pc", pc_o, 32'h0);
            if (r == 15) chk("wrap_next", mem_addr_o, 32'h0);
            step_post();
        end
        br_sig_i = 1'b0;
        stall_i  = 1'b0;

        // Reset asserted asynchronously during ISSUE3.
        step_pre();
        chk("issue3_addr", mem_addr_o, 32'h3);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(inst_valid_o), 32'h0);
        chk("mid_rst_inst", inst_o, 32'h0);
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_req", 32'(mem_req_o), 32'h0);
        chk("mid_rst_addr", mem_addr_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int r = 0; r < 6; r++) begin
            step_pre();
            if (r == 0) chk("restart_req", 32'(mem_req_o), 32'h1);
            if (r == 0) chk("restart_addr", mem_addr_o, 32'h0);
            if (r == 5) chk("restart_inst", inst_o, 32'h0010_0513);
            step_post();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RISC-V pipeline. It owns the fetch PC and reads each 32-bit instruction as four little-endian bytes over the shared byte-wide memory port. It presents the assembled instruction to the IF/ID register with a valid/stall handshake. It accepts one-cycle redirects from the decode stage, whose pc_sig/pc_o drive br_sig_i/br_target_i.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stall_i  in  1  downstream cannot accept; hold output
- br_sig_i  in  1  redirect request, one-cycle pulse
- br_target_i  in  32  redirect target; bits [1:0] forced to 0
- mem_busy_i  in  1  port not granted to fetch this cycle
- mem_data_i  in  8  read data, valid the cycle after a granted request
- mem_req_o  out  1  byte read request
- mem_addr_o  out  32  byte address
- inst_valid_o  out  1  inst_o/pc_o valid
- inst_o  out  32  assembled instruction
- pc_o  out  32  fetch address + 4; decode subtracts 4

## Operation
- Reset values:
  - fetch_pc = RESET_PC; state ISSUE0.
  - inst_valid_o = 0; inst_o = 0; pc_o = 0.
  - mem_req_o = 0; mem_addr_o = 0; pend_q = 0.
- States:
  - ISSUE0–ISSUE3: request byte k.
    - mem_req_o = !mem_busy_i; mem_addr_o = fetch_pc + k.
    - Advance to the next state only when !mem_busy_i; otherwise stay.
  - CAPTURE: receive byte 3; no request.
  - DONE: inst_valid_o = 1.
    - If !stall_i: fetch_pc += 4 and go to ISSUE0.
    - If stall_i: hold all outputs stable.
- Capture:
  - pend_q/pend_idx record a granted request.
  - The next cycle writes mem_data_i into byte[pend_idx], regardless of mem_busy_i that cycle.
- Assembly: inst_o = {b3, b2, b1, b0}; pc_o = fetch_pc + 4. Both are registered on CAPTURE→DONE.
- Redirect (br_sig_i = 1 in any state; highest priority over stall_i and mem_busy_i):
  - Next cycle: fetch_pc = {br_target_i[31:2], 2'b00}, state ISSUE0.
  - inst_valid_o = 0 and pend_q = 0; the in-flight byte is discarded.
  - No request is issued in the redirect cycle.
- Address arithmetic is modulo 2^32. Fetch at 0xFFFF_FFFC gives pc_o = 0 and next fetch_pc = 0.
- Reset asserted mid-fetch: immediate return to reset values; partial bytes are discarded.

## Timing
- Ungated fetch, first request in cycle 0:
  - cycles 0–3: requests for bytes 0–3.
  - cycles 1–4: captures.
  - cycle 5: inst_valid_o.
- Latency: 5 cycles from first request to valid. Throughput: 1 instruction / 6 cycles with no stalls.
- Each cycle with mem_busy_i = 1 during ISSUE adds 1 cycle.
- Each cycle with stall_i = 1 in DONE adds 1 cycle.
- Redirect asserted in cycle n: first request for the target in cycle n+1; valid no earlier than n+6.
- Outputs are registered except mem_req_o/mem_addr_o, which are combinational from state, fetch_pc and mem_busy_i. Both read 0 while rst = 0.

## Structure
- defines.v gains:
  - state encodings IF_ISSUE0..IF_DONE (3 bits).
  - `RstnEnable 1'b0.
  - `MemByteBus [7:0].
- Reuses `InstAddrBus and `InstBus.
- Single module, no sub-module. The fetch PC register lives inside; no separate pc_reg instance.

## Test plan
- Reset release, memory bytes 0..3 = 13 05 10 00 → inst_o = 32'h0010_0513, pc_o = 4, valid in cycle 5; next requests at addresses 4..7.
- stall_i high for 3 cycles in DONE → inst_o/pc_o/valid stable for those 3 cycles; request at address 4 issued the cycle after stall_i falls.
- mem_busy_i high in ISSUE1 for 2 cycles → mem_req_o = 0 in both cycles; byte 0 still captured; valid in cycle 7 with the correct word.
- br_sig_i with target 32'h0000_0103 during ISSUE2 → next address 0x100; old partial word never appears valid; pc_o = 0x104 when valid.
- Redirect coinciding with stall_i in DONE → valid drops next cycle; fetch at target begins.
- Fetch at 0xFFFF_FFFC → addresses FFFF_FFFC..FFFF_FFFF issued; pc_o = 0; next fetch at 0.
- rst low during ISSUE3 → all outputs 0 immediately; after release, fetch restarts at RESET_PC.
